// File: rtl/button_debounce.sv
// button_debounce
//
// Debounces a raw pushbutton/switch pin. The pin is first brought into the
// clock domain through a two-flop synchronizer. A small FSM then requires the
// synchronized level to differ from the current debounced level for
// DEBOUNCE_CYCLES consecutive edges before it accepts the new level.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new level
//                    (legal range 2 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH        width of the stability counter
//   RESET_LEVEL      level of devoutput (and the synchronizer) in reset
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESETn      in   asynchronous active-low reset
//   devinput    in   raw asynchronous button pin
//   devoutput   out  debounced, registered level
//   rise_pulse  out  one-cycle strobe when devoutput goes 0->1
//   fall_pulse  out  one-cycle strobe when devoutput goes 1->0
//   toggle_out  out  inverts on every accepted 1->0 transition (press)

module button_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic devinput,
  output logic devoutput,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 out_next;
  logic                 rise_next;
  logic                 fall_next;
  logic                 toggle_next;

  // Two-flop synchronizer. It resets to RESET_LEVEL so that a reset release
  // with the pin already at RESET_LEVEL does not look like a transition.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= devinput;
      sync2 <= sync1;
    end
  end

  // State, counter and all outputs are registered together so that the new
  // devoutput value and its pulse appear in the same cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      count      <= '0;
      devoutput  <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      toggle_out <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      devoutput  <= out_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      toggle_out <= toggle_next;
    end
  end

  // Next-state logic. The first edge that sees a difference already counts as
  // stable sample number one, so acceptance happens when the counter has
  // reached DEBOUNCE_CYCLES-1 and the difference is still present. Using >=
  // keeps the counter from ever running past its last value.
  always_comb begin
    state_next  = state;
    count_next  = count;
    out_next    = devoutput;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    toggle_next = toggle_out;

    case (state)
      IDLE: begin
        count_next = '0;
        if (sync2 != devoutput) begin
          state_next = COUNT;
          count_next = CNT_WIDTH'(1);
        end
      end

      COUNT: begin
        if (sync2 == devoutput) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count >= LAST_COUNT) begin
          state_next = IDLE;
          count_next = '0;
          out_next   = sync2;
          rise_next  = sync2;
          fall_next  = ~sync2;
          if (!sync2) begin
            toggle_next = ~toggle_out;
          end
        end else begin
          count_next = count + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//
// Table-driven bench for button_debounce with DEBOUNCE_CYCLES = 4 and
// RESET_LEVEL = 1. Each table row is one clock: inputs are driven at the
// falling edge, outputs are sampled 1 time unit after the following rising
// edge and compared against hand-computed {devoutput, rise, fall, toggle}.
// A hand-written sequence at the end covers reset asserted mid-count.

module tb_button_debounce;

  localparam int DEB = 4;

  logic CLK;
  logic RESETn;
  logic devinput;
  logic devoutput;
  logic rise_pulse;
  logic fall_pulse;
  logic toggle_out;

  int checks;
  int errors;

  typedef struct {
    logic       rst_n;
    logic       din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (4),
    .RESET_LEVEL    (1'b1)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .devinput  (devinput),
    .devoutput (devoutput),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Appends n identical rows: inputs and expected {out, rise, fall, toggle}.
  task automatic add(input logic r, input logic d, input logic o,
                     input logic rp, input logic fp, input logic t, input int n);
    vec_t v;
    v.rst_n = r;
    v.din   = d;
    v.exp   = {o, rp, fp, t};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Plays table rows lo..hi-1, one clock each.
  task automatic applyStimulus(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge CLK);
      RESETn   = vecs[i].rst_n;
      devinput = vecs[i].din;
      @(posedge CLK);
      #1;
      checkOutput($sformatf("row%0d", i),
                  {28'd0, devoutput, rise_pulse, fall_pulse, toggle_out},
                  {28'd0, vecs[i].exp});
    end
  endtask

  initial begin
    int seg1;
    int found;
    int edge_idx;

    checks   = 0;
    errors   = 0;
    RESETn   = 1'b0;
    devinput = 1'b1;

    // Reset held, then idle with the button released.
    add(0, 1, 1, 0, 0, 0, 3);
    add(1, 1, 1, 0, 0, 0, 20);
    // Bounce: low for 3 samples only, never accepted.
    add(1, 0, 1, 0, 0, 0, 3);
    add(1, 1, 1, 0, 0, 0, 8);
    seg1 = vecs.size();
    // Press 1: accepted 5 edges after the first low sample.
    add(1, 0, 1, 0, 0, 0, 5);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 4);
    // Release 1.
    add(1, 1, 0, 0, 0, 1, 5);
    add(1, 1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 4);
    // Press 2: toggle goes back to 0.
    add(1, 0, 1, 0, 0, 1, 5);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4);
    // Release 2.
    add(1, 1, 0, 0, 0, 0, 5);
    add(1, 1, 1, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 4);
    // Press 3 and release 3 so toggle is 1 entering the reset test.
    add(1, 0, 1, 0, 0, 0, 5);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 4);
    add(1, 1, 0, 0, 0, 1, 5);
    add(1, 1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 4);
    // Start a press and stop with the counter at 2.
    add(1, 0, 1, 0, 0, 1, 4);

    applyStimulus(0, seg1);
    checkOutput("bounce_count_zero", 32'(dut.count), 32'd0);

    applyStimulus(seg1, vecs.size());
    checkOutput("midcount_count_two", 32'(dut.count), 32'd2);

    // Asynchronous reset in the middle of a clock period.
    @(negedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {28'd0, devoutput, rise_pulse, fall_pulse, toggle_out}, 32'b1000);
    checkOutput("async_reset_count", 32'(dut.count), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("held_reset_outputs",
                {28'd0, devoutput, rise_pulse, fall_pulse, toggle_out}, 32'b1000);

    // Release reset with the button still pressed: full debounce again.
    @(negedge CLK);
    RESETn   = 1'b1;
    devinput = 1'b0;
    found    = 0;
    edge_idx = -1;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(posedge CLK);
      #1;
      if (rise_pulse) begin
        checkOutput("post_reset_no_rise", 32'(rise_pulse), 32'd0);
      end
      if (fall_pulse) begin
        found    = 1;
        edge_idx = k;
      end
    end
    checkOutput("post_reset_fall_seen", 32'(found), 32'd1);
    checkOutput("post_reset_fall_edge", 32'(edge_idx), 32'd5);
    checkOutput("post_reset_out_toggle",
                {30'd0, devoutput, toggle_out}, 32'b01);
    @(posedge CLK);
    #1;
    checkOutput("post_reset_fall_one_cycle", 32'(fall_pulse), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
